hwpe_axi_stream_sink: RTL and testbench



---
 rtl/hwpe_axi_stream_sink.sv | 160 ++++++++++++++++
 tb/tb_hwpe_axi_stream_sink.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_axi_stream_sink.sv
// Stream-to-TCDM write sink: takes valid/ready beats and writes them at 3-level strided addresses.
// Optional grant-stall counter enabled by defining HWPE_SINK_STALL_CNT_EN.
module hwpe_axi_stream_sink #(
  parameter int unsigned CLUS_ADDR_WIDTH     = 32,
  parameter int unsigned CLUS_DATA_WIDTH     = 32,
  parameter int unsigned CLUS_BE_WIDTH       = CLUS_DATA_WIDTH/8,
  parameter logic [31:0] WORD_STRIDE         = 32'h4,
  parameter int unsigned STREAM_COUNTER_BITS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           start_i,
  input  logic [31:0]                    base_addr_i,
  input  logic [STREAM_COUNTER_BITS-1:0] trans_size_i,
  input  logic [15:0]                    line_length_i,
  input  logic [15:0]                    line_stride_i,
  input  logic [15:0]                    feat_length_i,
  input  logic [15:0]                    feat_stride_i,
  input  logic [CLUS_DATA_WIDTH-1:0]     data_i,
  input  logic [CLUS_BE_WIDTH-1:0]       strb_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic                           tcdm_req_o,
  output logic [CLUS_ADDR_WIDTH-1:0]     tcdm_add_o,
  output logic                           tcdm_wen_o,
  output logic [CLUS_BE_WIDTH-1:0]       tcdm_be_o,
  output logic [CLUS_DATA_WIDTH-1:0]     tcdm_data_o,
  input  logic                           tcdm_gnt_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [31:0]                    stall_cnt_o
);
  localparam int unsigned AW  = CLUS_ADDR_WIDTH;
  localparam int unsigned SCB = STREAM_COUNTER_BITS;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [AW-1:0]  base;
    logic [SCB-1:0] size;
    logic [15:0]    len;
    logic [15:0]    flen;
    logic [AW-1:0]  lstride;
    logic [AW-1:0]  fstride;
  } cfg_t;

  state_t         state_q, state_d;
  cfg_t           cfg_q;
  logic [15:0]    word_cnt, line_cnt;
  logic [AW-1:0]  word_off, line_off, feat_off;
  logic [SCB-1:0] acc_cnt, gnt_cnt;
  logic           start_cond, accept, grant, last_gnt;

  assign start_cond = (state_q == IDLE) && start_i && en;
  assign grant      = tcdm_req_o && tcdm_gnt_i;
  assign last_gnt   = grant && (gnt_cnt == cfg_q.size - 1'b1);
  assign ready_o    = (state_q == RUN) && (acc_cnt < cfg_q.size) && (!tcdm_req_o || tcdm_gnt_i);
  assign accept     = valid_i && ready_o;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign tcdm_wen_o = ~tcdm_req_o;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (trans_size_i == '0) ? DONE : RUN;
      RUN:     if (last_gnt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!en) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q       <= '0;
      word_cnt    <= '0;
      line_cnt    <= '0;
      word_off    <= '0;
      line_off    <= '0;
      feat_off    <= '0;
      acc_cnt     <= '0;
      gnt_cnt     <= '0;
      tcdm_req_o  <= 1'b0;
      tcdm_add_o  <= '0;
      tcdm_be_o   <= '0;
      tcdm_data_o <= '0;
    end else if (!en) begin
      // abort: pending beat is discarded along with all progress
      word_cnt   <= '0;
      line_cnt   <= '0;
      word_off   <= '0;
      line_off   <= '0;
      feat_off   <= '0;
      acc_cnt    <= '0;
      gnt_cnt    <= '0;
      tcdm_req_o <= 1'b0;
    end else begin
      if (start_cond) begin
        cfg_q.base    <= base_addr_i;
        cfg_q.size    <= trans_size_i;
        cfg_q.len     <= (line_length_i == '0) ? 16'd1 : line_length_i;
        cfg_q.flen    <= (feat_length_i == '0) ? 16'd1 : feat_length_i;
        cfg_q.lstride <= {{(AW-16){line_stride_i[15]}}, line_stride_i};
        cfg_q.fstride <= {{(AW-16){feat_stride_i[15]}}, feat_stride_i};
        word_cnt      <= '0;
        line_cnt      <= '0;
        word_off      <= '0;
        line_off      <= '0;
        feat_off      <= '0;
        acc_cnt       <= '0;
        gnt_cnt       <= '0;
      end
      if (accept) begin
        tcdm_req_o  <= 1'b1;
        tcdm_add_o  <= cfg_q.base + feat_off + line_off + word_off;
        tcdm_data_o <= data_i;
        tcdm_be_o   <= strb_i;
        acc_cnt     <= acc_cnt + 1'b1;
        if (word_cnt < cfg_q.len - 16'd1) begin
          word_cnt <= word_cnt + 16'd1;
          word_off <= word_off + WORD_STRIDE[AW-1:0];
        end else if (line_cnt < cfg_q.flen - 16'd1) begin
          word_cnt <= '0;
          line_cnt <= line_cnt + 16'd1;
          word_off <= '0;
          line_off <= line_off + cfg_q.lstride;
        end else begin
          word_cnt <= '0;
          line_cnt <= '0;
          word_off <= '0;
          line_off <= '0;
          feat_off <= feat_off + cfg_q.fstride;
        end
      end else if (grant) begin
        tcdm_req_o <= 1'b0;
      end
      if (grant) gnt_cnt <= gnt_cnt + 1'b1;
    end
  end

`ifdef HWPE_SINK_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst)                             stall_q <= '0;
    else if (start_cond)                 stall_q <= '0;
    else if (tcdm_req_o && !tcdm_gnt_i)  stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_axi_stream_sink.sv
// Randomized bench for hwpe_axi_stream_sink: expected addresses come from index arithmetic,
// expected data from a scoreboard of accepted beats.
module tb_hwpe_axi_stream_sink;
  logic        clk = 1'b0;
  logic        rst, en, start_i;
  logic [31:0] base_addr_i;
  logic [15:0] trans_size_i, line_length_i, line_stride_i, feat_length_i, feat_stride_i;
  logic [31:0] data_i;
  logic [3:0]  strb_i;
  logic        valid_i, ready_o;
  logic        tcdm_req_o, tcdm_wen_o, tcdm_gnt_i;
  logic [31:0] tcdm_add_o, tcdm_data_o;
  logic [3:0]  tcdm_be_o;
  logic        busy_o, done_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hwpe_axi_stream_sink dut (
    .clk(clk), .rst(rst), .en(en), .start_i(start_i),
    .base_addr_i(base_addr_i), .trans_size_i(trans_size_i),
    .line_length_i(line_length_i), .line_stride_i(line_stride_i),
    .feat_length_i(feat_length_i), .feat_stride_i(feat_stride_i),
    .data_i(data_i), .strb_i(strb_i), .valid_i(valid_i), .ready_o(ready_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o), .tcdm_gnt_i(tcdm_gnt_i),
    .busy_o(busy_o), .done_o(done_o), .stall_cnt_o(stall_cnt_o)
  );

  // Beat i lives at word (i mod L), line ((i/L) mod F), feature (i/(L*F)).
  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int L, input int F,
                                           input logic [15:0] ls, input logic [15:0] fs, input int i);
    int lsi, fsi, off;
    lsi = int'($signed(ls));
    fsi = int'($signed(fs));
    off = (i / (L * F)) * fsi + ((i / L) % F) * lsi + (i % L) * 4;
    return base + 32'(off);
  endfunction

  task automatic run_xfer(input logic [31:0] base, input logic [15:0] size, input logic [15:0] len,
                          input logic [15:0] ls, input logic [15:0] flen, input logic [15:0] fs,
                          input int vprob, input int gprob, input int hold_beat, input int hold_n,
                          input int abort_at, input int exp_cycles, input string name);
    logic [31:0] dq[$];
    logic [3:0]  bq[$];
    logic [31:0] ea, pd, pa;
    logic [3:0]  pb;
    int L, F, acc, gcnt, stalls, held, last_g, cyc, exp_stall;
    bit fin, prev_hold, hold_now;
    L = (len == 0) ? 1 : int'(len);
    F = (flen == 0) ? 1 : int'(flen);
    acc = 0; gcnt = 0; stalls = 0; held = 0; last_g = -10; cyc = 0;
    fin = 0; prev_hold = 0; pd = '0; pa = '0; pb = '0;
    @(negedge clk);
    base_addr_i = base; trans_size_i = size; line_length_i = len; line_stride_i = ls;
    feat_length_i = flen; feat_stride_i = fs; start_i = 1'b1; valid_i = 1'b0; tcdm_gnt_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    // config must be ignored once latched
    base_addr_i = $urandom; trans_size_i = 16'($urandom); line_length_i = 16'($urandom);
    line_stride_i = 16'($urandom); feat_length_i = 16'($urandom); feat_stride_i = 16'($urandom);
    while (!fin) begin
      cyc++;
      valid_i = ($urandom_range(99) < vprob);
      data_i  = $urandom;
      strb_i  = 4'($urandom);
      hold_now = tcdm_req_o && (gcnt == hold_beat) && (held < hold_n);
      if (hold_now) held++;
      tcdm_gnt_i = hold_now ? 1'b0 : ($urandom_range(99) < gprob);
      #1;
      if (done_o) begin
        checks++;
        if (gcnt != int'(size) || acc != int'(size))
          begin errors++; $display("FAIL %s count: granted %0d accepted %0d, required %0d", name, gcnt, acc, size); end
        checks++;
        if (cyc != ((size == 0) ? 1 : last_g + 1))
          begin errors++; $display("FAIL %s done_timing: cycle %0d, last grant %0d", name, cyc, last_g); end
        checks++;
        if (tcdm_req_o !== 1'b0 || busy_o !== 1'b1)
          begin errors++; $display("FAIL %s done_state: req %b busy %b, required 0 1", name, tcdm_req_o, busy_o); end
        if (exp_cycles >= 0) begin
          checks++;
          if (cyc != exp_cycles)
            begin errors++; $display("FAIL %s throughput: done at cycle %0d, required %0d", name, cyc, exp_cycles); end
        end
`ifdef HWPE_SINK_STALL_CNT_EN
        exp_stall = stalls;
`else
        exp_stall = 0;
`endif
        checks++;
        if (stall_cnt_o !== 32'(exp_stall))
          begin errors++; $display("FAIL %s stall_cnt: got %0d, required %0d", name, stall_cnt_o, exp_stall); end
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0)
          begin errors++; $display("FAIL %s after_done: done %b busy %b, required 0 0", name, done_o, busy_o); end
        fin = 1;
      end else begin
        if (prev_hold) begin
          checks++;
          if (tcdm_req_o !== 1'b1 || tcdm_add_o !== pa || tcdm_data_o !== pd || tcdm_be_o !== pb)
            begin errors++; $display("FAIL %s hold: req %b add %h data %h, required 1 %h %h", name, tcdm_req_o, tcdm_add_o, tcdm_data_o, pa, pd); end
        end
        if (tcdm_req_o && !tcdm_gnt_i && ready_o)
          begin checks++; errors++; $display("FAIL %s ready_while_held: ready 1, required 0", name); end
        if (ready_o && acc >= int'(size))
          begin checks++; errors++; $display("FAIL %s ready_overrun: ready 1 after %0d beats", name, acc); end
        if (tcdm_req_o && tcdm_wen_o !== 1'b0)
          begin checks++; errors++; $display("FAIL %s wen: got %b, required 0", name, tcdm_wen_o); end
        if (tcdm_req_o && tcdm_gnt_i) begin
          checks++;
          if (dq.size() == 0) begin
            errors++; $display("FAIL %s spurious_req: add %h with no beat pending", name, tcdm_add_o);
          end else begin
            ea = exp_addr(base, L, F, ls, fs, gcnt);
            pd = dq.pop_front();
            pb = bq.pop_front();
            if (tcdm_add_o !== ea || tcdm_data_o !== pd || tcdm_be_o !== pb)
              begin errors++; $display("FAIL %s beat%0d: add %h data %h be %h, required %h %h %h", name, gcnt, tcdm_add_o, tcdm_data_o, tcdm_be_o, ea, pd, pb); end
          end
          gcnt++;
          last_g = cyc;
        end
        if (tcdm_req_o && !tcdm_gnt_i) stalls++;
        prev_hold = tcdm_req_o && !tcdm_gnt_i;
        pa = tcdm_add_o; pd = tcdm_data_o; pb = tcdm_be_o;
        if (valid_i && ready_o) begin dq.push_back(data_i); bq.push_back(strb_i); acc++; end
        if (abort_at >= 0 && gcnt >= abort_at) begin
          @(negedge clk);
          en = 1'b0;
          valid_i = 1'b1;
          tcdm_gnt_i = 1'b0;
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (busy_o !== 1'b0 || tcdm_req_o !== 1'b0 || done_o !== 1'b0 || ready_o !== 1'b0)
              begin errors++; $display("FAIL %s abort: busy %b req %b done %b ready %b, required 0", name, busy_o, tcdm_req_o, done_o, ready_o); end
          end
          en = 1'b1;
          valid_i = 1'b0;
          fin = 1;
        end
      end
      if (!fin && cyc > 2000) begin
        checks++; errors++;
        $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; start_i = 1'b1; valid_i = 1'b1; tcdm_gnt_i = 1'b0;
    base_addr_i = 32'h1000; trans_size_i = 16'd4; line_length_i = 16'd4; line_stride_i = '0;
    feat_length_i = 16'd1; feat_stride_i = '0; data_i = '0; strb_i = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || tcdm_req_o !== 1'b0 || tcdm_wen_o !== 1'b1 || tcdm_add_o !== 32'h0 ||
        tcdm_be_o !== 4'h0 || tcdm_data_o !== 32'h0 || busy_o !== 1'b0 || done_o !== 1'b0 || stall_cnt_o !== 32'h0)
      begin errors++; $display("FAIL reset: ready %b req %b wen %b add %h busy %b done %b stall %0d", ready_o, tcdm_req_o, tcdm_wen_o, tcdm_add_o, busy_o, done_o, stall_cnt_o); end
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0)
      begin errors++; $display("FAIL reset_idle: busy %b, required 0", busy_o); end
  endtask

  task automatic test_linear();
    run_xfer(32'h1000, 16'd4, 16'd4, 16'h0, 16'd1, 16'h0, 100, 100, -1, 0, -1, 6, "linear");
  endtask

  task automatic test_back_to_back();
    run_xfer(32'h2000, 16'd8, 16'd2, 16'h100, 16'd2, 16'h1000, 100, 100, -1, 0, -1, 10, "strided");
  endtask

  task automatic test_gnt_stall();
    run_xfer(32'h4000, 16'd4, 16'd4, 16'h0, 16'd1, 16'h0, 100, 100, 1, 3, -1, 9, "stall");
  endtask

  task automatic test_neg_stride();
    run_xfer(32'h100, 16'd3, 16'd1, 16'hFFF0, 16'd3, 16'h0, 100, 100, -1, 0, -1, 5, "negstride");
  endtask

  task automatic test_zero_size();
    run_xfer(32'h500, 16'd0, 16'd4, 16'h0, 16'd1, 16'h0, 100, 100, -1, 0, -1, 1, "zerosize");
  endtask

  task automatic test_abort();
    run_xfer(32'h8000, 16'd8, 16'd4, 16'h40, 16'd2, 16'h200, 100, 100, -1, 0, 2, -1, "abort");
    run_xfer(32'h8000, 16'd8, 16'd4, 16'h40, 16'd2, 16'h200, 100, 100, -1, 0, -1, 10, "restart");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++)
      run_xfer($urandom, 16'($urandom_range(20, 1)), 16'($urandom_range(3)),
               16'($urandom_range(255) - 128), 16'($urandom_range(3)),
               16'($urandom_range(8191) - 4096), 60, 60, -1, 0, -1, -1, "random");
  endtask

  initial begin
    test_reset();
    test_linear();
    test_back_to_back();
    test_gnt_stall();
    test_neg_stride();
    test_zero_size();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
